// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue/writeback controller for a 16-bit combinational ALU.
//            Accepts one instruction at a time on a valid/ready handshake.
//            It reads operands from a small register file and drives the ALU.
//            It captures the ALU result, writes it back to the register file
//            and returns it on a valid/ready response port.
//            Each instruction takes IDLE -> EXEC -> RESP, so the controller
//            issues at most one instruction every 3 cycles.
// Options  : CARRY_CHAIN_EN - when defined, ALU inC comes from an internal
//            carry flag (c_flag) that add ops (opc 010) update. in_cin is
//            then ignored. When undefined, inC is the latched in_cin.
// Ports    : clk, rst                      - clock, sync active-high reset
//            in_valid/in_ready             - instruction handshake
//            in_load, in_opc, in_dst,
//            in_srcA, in_srcB, in_cin,
//            in_data                       - instruction fields
//            alu_inA/inB/inC/opc           - operands and opcode to the ALU
//            alu_outW/zer/neg              - result and flags from the ALU
//            res_valid/res_ready           - response handshake
//            res_data, res_dst,
//            res_zer, res_neg              - response payload
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [2:0]        in_opc,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [REG_AW-1:0] in_srcA,
  input  logic [REG_AW-1:0] in_srcB,
  input  logic              in_cin,
  input  logic [15:0]       in_data,
  output logic [15:0]       alu_inA,
  output logic [15:0]       alu_inB,
  output logic              alu_inC,
  output logic [2:0]        alu_opc,
  input  logic [15:0]       alu_outW,
  input  logic              alu_zer,
  input  logic              alu_neg,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [REG_AW-1:0] res_dst,
  output logic              res_zer,
  output logic              res_neg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OPC_ADD = 3'b010;

  logic [1:0]        state;
  logic [1:0]        state_next;

  // Latched instruction fields
  logic              r_load;
  logic [2:0]        r_opc;
  logic [REG_AW-1:0] r_dst;
  logic [REG_AW-1:0] r_srcA;
  logic [REG_AW-1:0] r_srcB;
  logic [15:0]       r_data;

  logic [15:0]       regs [NUM_REGS];

  logic              w_accept;
  logic              w_exec;
  logic [15:0]       w_result;
  logic              w_zer;
  logic              w_neg;

  assign w_accept = (state == S_IDLE) && in_valid;
  assign w_exec   = (state == S_EXEC);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)  state_next = S_EXEC;
      S_EXEC:                 state_next = S_RESP;
      S_RESP:  if (res_ready) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_RESP:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction capture. The fields are only written on accept. The ALU ports
  // stay driven from known values in every state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load <= 1'b0;
      r_opc  <= '0;
      r_dst  <= '0;
      r_srcA <= '0;
      r_srcB <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_load <= in_load;
      r_opc  <= in_opc;
      r_dst  <= in_dst;
      r_srcA <= in_srcA;
      r_srcB <= in_srcB;
      r_data <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // ALU drive
  // --------------------------------------------------------------------------
  assign alu_inA = regs[r_srcA];
  assign alu_inB = regs[r_srcB];
  assign alu_opc = r_opc;

`ifdef CARRY_CHAIN_EN
  logic        c_flag;
  logic [16:0] w_sum;
  logic        w_unused_cin;

  // Recompute the add locally so the carry-out does not depend on the ALU.
  assign w_sum        = {1'b0, alu_inA} + {1'b0, alu_inB} + {16'd0, c_flag};
  assign alu_inC      = c_flag;
  assign w_unused_cin = in_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_flag <= 1'b0;
    end else if (w_exec && !r_load && (r_opc == OPC_ADD)) begin
      c_flag <= w_sum[16];
    end
  end
`else
  logic r_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cin <= 1'b0;
    end else if (w_accept) begin
      r_cin <= in_cin;
    end
  end

  assign alu_inC = r_cin;
`endif

  // --------------------------------------------------------------------------
  // Writeback and response capture. Loads bypass the ALU, so their flags are
  // derived here from the immediate.
  // --------------------------------------------------------------------------
  assign w_result = r_load ? r_data : alu_outW;
  assign w_zer    = r_load ? (r_data == 16'h0000) : alu_zer;
  assign w_neg    = r_load ? r_data[15] : alu_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      res_data <= '0;
      res_dst  <= '0;
      res_zer  <= 1'b0;
      res_neg  <= 1'b0;
    end else if (w_exec) begin
      regs[r_dst] <= w_result;
      res_data    <= w_result;
      res_dst     <= r_dst;
      res_zer     <= w_zer;
      res_neg     <= w_neg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. It contains a behavioural
//            ALU and a scoreboard of expected responses. A register-file
//            model predicts each result when the instruction is issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic [2:0]  in_opc;
  logic [1:0]  in_dst;
  logic [1:0]  in_srcA;
  logic [1:0]  in_srcB;
  logic        in_cin;
  logic [15:0] in_data;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic        alu_inC;
  logic [2:0]  alu_opc;
  logic [15:0] alu_outW;
  logic        alu_zer;
  logic        alu_neg;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_dst;
  logic        res_zer;
  logic        res_neg;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  dst;
    logic        zer;
    logic        neg;
  } resp_t;

  resp_t       q[$];
  logic [15:0] m_regs [4];
  logic        m_c;
  int          checks;
  int          errors;

  // ALU encoding: 000 -A, 001 A+1, 010 A+B+C, 011 A-B, 100 A&B, 101 A|B,
  // 110 {A[7:0],B[7:0]}, 111 clear
  function automatic logic [15:0] alu_ref(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    case (opc)
      3'b000:  return 16'h0000 - a;
      3'b001:  return a + 16'h0001;
      3'b010:  return a + b + {15'd0, c};
      3'b011:  return a - b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return {a[7:0], b[7:0]};
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_outW = alu_ref(alu_opc, alu_inA, alu_inB, alu_inC);
  assign alu_zer  = (alu_outW == 16'h0000);
  assign alu_neg  = alu_outW[15];

  alu_issue_ctrl #(.NUM_REGS(4), .REG_AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_opc(in_opc),
    .in_dst(in_dst), .in_srcA(in_srcA), .in_srcB(in_srcB), .in_cin(in_cin),
    .in_data(in_data),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .res_zer(res_zer), .res_neg(res_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
    m_c = 1'b0;
    q.delete();
  endtask

  // Drive one instruction, predict its response, and check the 2-cycle latency.
  task automatic send_instr(input logic ld, input logic [2:0] opc, input logic [1:0] dst,
                            input logic [1:0] sa, input logic [1:0] sb, input logic cin,
                            input logic [15:0] data, input bit hold_valid);
    int          n;
    logic [16:0] sum;
    logic        c_eff;
    resp_t       e;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_load = ld; in_opc = opc; in_dst = dst;
    in_srcA = sa; in_srcB = sb; in_cin = cin; in_data = data;
`ifdef CARRY_CHAIN_EN
    c_eff = m_c;
`else
    c_eff = cin;
`endif
    if (ld) e.data = data;
    else    e.data = alu_ref(opc, m_regs[sa], m_regs[sb], c_eff);
`ifdef CARRY_CHAIN_EN
    if (!ld && opc == 3'b010) begin
      sum = {1'b0, m_regs[sa]} + {1'b0, m_regs[sb]} + {16'd0, m_c};
      m_c = sum[16];
    end
`else
    sum = '0;
`endif
    e.dst = dst;
    e.zer = (e.data == 16'h0000);
    e.neg = e.data[15];
    m_regs[dst] = e.data;
    q.push_back(e);
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: res_valid=%b required 0 one cycle after accept", res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: res_valid=%b required 1 two cycles after accept", res_valid);
    end
  endtask

  // Pop the oldest expected response, compare it, then complete the handshake.
  task automatic expect_resp(input string name);
    int    n;
    resp_t e;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (res_valid !== 1'b1 || q.size() == 0) begin
      errors++;
      $display("FAIL %s_resp_valid: res_valid=%b queued=%0d required valid with 1 queued",
               name, res_valid, q.size());
      return;
    end
    e = q.pop_front();
    checks++;
    if (res_data !== e.data) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, res_data, e.data);
    end
    checks++;
    if (res_dst !== e.dst) begin
      errors++;
      $display("FAIL %s_dst: got %0d required %0d", name, res_dst, e.dst);
    end
    checks++;
    if (res_zer !== e.zer || res_neg !== e.neg) begin
      errors++;
      $display("FAIL %s_flags: got zer=%b neg=%b required zer=%b neg=%b",
               name, res_zer, res_neg, e.zer, e.neg);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_in_resp: in_ready=%b required 0", name, in_ready);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_hs: in_ready=%b res_valid=%b required 1 and 0",
               name, in_ready, res_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b res_valid=%b required 1 and 0", in_ready, res_valid);
    end
    checks++;
    if (res_data !== 16'h0000 || res_dst !== 2'd0 || res_zer !== 1'b0 || res_neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_res: data=%h dst=%0d zer=%b neg=%b required all 0",
               res_data, res_dst, res_zer, res_neg);
    end
    checks++;
    if (alu_inA !== 16'h0000 || alu_inB !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: inA=%h inB=%h required 0000", alu_inA, alu_inB);
    end
  endtask

  task automatic test_add();
    send_instr(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0005, 1'b0); expect_resp("load_r0");
    send_instr(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0003, 1'b0); expect_resp("load_r1");
    send_instr(1'b0, 3'b010, 2'd2, 2'd0, 2'd1, 1'b1, 16'h0000, 1'b0); expect_resp("add_cin");
    send_instr(1'b0, 3'b010, 2'd3, 2'd2, 2'd0, 1'b0, 16'h0000, 1'b0); expect_resp("add_raw");
  endtask

  task automatic test_negate();
    send_instr(1'b0, 3'b000, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0); expect_resp("negate");
    send_instr(1'b0, 3'b011, 2'd1, 2'd0, 2'd3, 1'b0, 16'h0000, 1'b0); expect_resp("sub");
  endtask

  task automatic test_bytes_and();
    send_instr(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 16'h1234, 1'b0); expect_resp("load_1234");
    send_instr(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 16'hABCD, 1'b0); expect_resp("load_abcd");
    send_instr(1'b0, 3'b110, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0); expect_resp("bytes");
    send_instr(1'b0, 3'b100, 2'd3, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0); expect_resp("and");
  endtask

  task automatic test_alias_clear();
    send_instr(1'b0, 3'b010, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0000, 1'b0); expect_resp("alias_add");
    send_instr(1'b0, 3'b001, 2'd3, 2'd3, 2'd0, 1'b0, 16'h0000, 1'b0); expect_resp("alias_inc");
    send_instr(1'b0, 3'b111, 2'd2, 2'd2, 2'd2, 1'b0, 16'h0000, 1'b0); expect_resp("clear");
    send_instr(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 16'h8000, 1'b0); expect_resp("load_neg");
    send_instr(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0); expect_resp("load_zero");
    send_instr(1'b0, 3'b101, 2'd0, 2'd1, 2'd3, 1'b0, 16'h0000, 1'b0); expect_resp("or");
  endtask

  task automatic test_backpressure();
    resp_t e;
    send_instr(1'b0, 3'b001, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000, 1'b1);
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== e.data || res_dst !== e.dst) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b data=%h dst=%0d required 1 0 %h %0d",
                 i, res_valid, in_ready, res_data, res_dst, e.data, e.dst);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    expect_resp("backpressure");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_extra[%0d]: res_valid=%b required 0", i, res_valid);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    in_valid = 1'b1; in_load = 1'b0; in_opc = 3'b001; in_dst = 2'd0;
    in_srcA = 2'd1; in_srcB = 2'd1; in_cin = 1'b0; in_data = 16'h0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'h0000 || res_dst !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_state: ready=%b valid=%b data=%h dst=%0d required 1 0 0000 0",
               in_ready, res_valid, res_data, res_dst);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_noresp[%0d]: res_valid=%b required 0", i, res_valid);
      end
    end
    send_instr(1'b0, 3'b001, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0); expect_resp("post_reset_inc");
    send_instr(1'b0, 3'b101, 2'd0, 2'd2, 2'd3, 1'b0, 16'h0000, 1'b0); expect_resp("post_reset_or");
  endtask

`ifdef CARRY_CHAIN_EN
  task automatic test_carry();
    send_instr(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 16'hFFFF, 1'b0); expect_resp("load_ffff");
    send_instr(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0001, 1'b0); expect_resp("load_0001");
    send_instr(1'b0, 3'b010, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 1'b0); expect_resp("carry_out");
    checks++;
    if (dut.c_flag !== m_c) begin
      errors++;
      $display("FAIL carry_flag_set: c_flag=%b required %b", dut.c_flag, m_c);
    end
    send_instr(1'b0, 3'b010, 2'd3, 2'd2, 2'd2, 1'b0, 16'h0000, 1'b0); expect_resp("carry_in");
    checks++;
    if (dut.c_flag !== m_c) begin
      errors++;
      $display("FAIL carry_flag_clr: c_flag=%b required %b", dut.c_flag, m_c);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_opc = 3'b000; in_dst = 2'd0;
    in_srcA = 2'd0; in_srcB = 2'd0; in_cin = 1'b0; in_data = 16'h0000; res_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_add();
    test_negate();
    test_bytes_and();
    test_alias_clear();
    test_backpressure();
    test_reset_mid_exec();
`ifdef CARRY_CHAIN_EN
    test_carry();
`endif
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
